// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
// Holds the MDU op codes and the two latency constants. The decoder, the
// hazard unit and mult_div_unit all import this package so the encodings
// and the stall lengths stay consistent.
//
// Configuration macro: MDU_MADD_EN (enables MADD/MADDU as multi-cycle ops).
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } mdu_op_e;

    localparam logic [3:0] LAT_MUL = 4'd5;
    localparam logic [3:0] LAT_DIV = 4'd10;

    // True for ops that occupy the unit for LAT_MUL/LAT_DIV cycles.
    function automatic logic is_multi_op(input mdu_op_e op);
        logic v;
        v = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: v = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  v = 1'b1;
`endif
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] op_latency(input mdu_op_e op);
        return ((op == OP_DIV) || (op == OP_DIVU)) ? LAT_DIV : LAT_MUL;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit -- HI/LO multiply/divide unit for the E stage.
//
// The result is computed combinationally from the operands present on the
// start edge and parked in pending registers; a countdown then models the
// architectural latency, and HI/LO take the pending value as the count goes
// 1 -> 0.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   A        in   [31:0] forwarded rs operand
//   B        in   [31:0] forwarded rt operand
//   mdu_op   in   [3:0]  op code (mdu_pkg::mdu_op_e)
//   start    in   one-cycle qualifier for multi-cycle ops
//   busy     out  computation in flight (count != 0)
//   hi, lo   out  [31:0] architectural HI/LO
//   mdu_out  out  [31:0] HI for MFHI, LO for MFLO, else 0 (combinational)
//
// Configuration macro: MDU_MADD_EN -- when defined, MADD/MADDU accumulate the
// product into {HI,LO}; when undefined they behave as NONE.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    mdu_op_e     w_op;
    logic        w_start_ok;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_den_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_res;

    assign w_op       = mdu_op_e'(mdu_op);
    assign w_start_ok = start && is_multi_op(w_op);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both DIV and DIVU. Signed division runs on
    // magnitudes and fixes signs afterwards, which also gives the wrapped
    // 0x80000000 / -1 result without relying on signed-overflow behaviour.
    assign w_signed_div = (w_op == OP_DIV);
    assign w_num        = (w_signed_div && A[31]) ? (32'd0 - A) : A;
    assign w_den        = (w_signed_div && B[31]) ? (32'd0 - B) : B;
    assign w_den_safe   = (B == 32'd0) ? 32'd1 : w_den;
    assign w_q_mag      = w_num / w_den_safe;
    assign w_r_mag      = w_num % w_den_safe;
    assign w_q = (w_signed_div && (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r = (w_signed_div && A[31])           ? (32'd0 - w_r_mag) : w_r_mag;

    // Divide by zero parks the current HI/LO as the pending result, so the
    // final write leaves them unchanged (MTHI/MTLO are locked out meanwhile).
    always_comb begin
        w_res = {r_hi, r_lo};
        case (w_op)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_DIV,
            OP_DIVU:  if (B != 32'd0) w_res = {w_r, w_q};
`ifdef MDU_MADD_EN
            OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
            OP_MADDU: w_res = {r_hi, r_lo} + w_prod_u;
`endif
            default:  w_res = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_start_ok) begin
            r_count   <= op_latency(w_op);
            r_pend_hi <= w_res[63:32];
            r_pend_lo <= w_res[31:0];
        end else if (w_op == OP_MTHI) begin
            r_hi <= A;
        end else if (w_op == OP_MTLO) begin
            r_lo <= A;
        end
    end

    assign busy = (r_count != 4'd0);
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        mdu_out = 32'd0;
        if (w_op == OP_MFHI) mdu_out = r_hi;
        else if (w_op == OP_MFLO) mdu_out = r_lo;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  mdu_op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .mdu_op  (mdu_op),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic tb_is_multi(input logic [3:0] op);
        if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
        if (op == OP_MADD || op == OP_MADDU) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Architectural result of an op on (a, b) given HI/LO at issue.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] cur, up;
        cur = {h, l};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        up  = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return up;
            OP_DIV: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU:  return (b == 32'd0) ? cur : {a % b, a / b};
            OP_MADD:  return cur + 64'(sa * sb);
            OP_MADDU: return cur + up;
            default:  return cur;
        endcase
    endfunction

    // Monitor: every busy 1->0 transition outside reset is a completion.
    int   busy_len  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            busy_len  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_len++;
            else if (prev_busy) begin
                if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else begin
                    mon_e = sb_q.pop_front();
                    check("busy_len", 64'(busy_len), 64'(mon_e.lat));
                    check("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                    check("lo", {32'd0, lo}, {32'd0, mon_e.lo});
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic do_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        exp_t        e;
        @(negedge clk);
        A = a; B = b; mdu_op = op; start = 1'b1;
        if (tb_is_multi(op)) begin
            res   = model(op, a, b, m_hi, m_lo);
            e.hi  = res[63:32];
            e.lo  = res[31:0];
            e.lat = (op == OP_DIV || op == OP_DIVU) ? 10 : 5;
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0; mdu_op = OP_NONE;
        if (!tb_is_multi(op)) begin
            check("nonmulti_busy", {63'd0, busy}, 64'd0);
            check("nonmulti_hilo", {hi, lo}, {m_hi, m_lo});
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || sb_q.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        A = a; mdu_op = op; start = 1'b0;
        @(negedge clk);
        mdu_op = OP_NONE;
        if (op == OP_MTHI) m_hi = a; else m_lo = a;
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
        check("mt_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_out();
        @(negedge clk);
        mdu_op = OP_MFHI; #1;
        check("mfhi", {32'd0, mdu_out}, {32'd0, m_hi});
        mdu_op = OP_MFLO; #1;
        check("mflo", {32'd0, mdu_out}, {32'd0, m_lo});
        mdu_op = OP_MULT; #1;
        check("mdu_out_other", {32'd0, mdu_out}, 64'd0);
        mdu_op = OP_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_lo, a, b;
        logic [3:0]  op;
        reset = 1'b1; A = '0; B = '0; mdu_op = OP_NONE; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        check_out();

        // Scenario 1 / 2
        do_multi(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_idle();
        check("s1", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        do_multi(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        check("s2", {hi, lo}, 64'hFFFFFFFE_00000001);

        // Scenario 3
        do_multi(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        check("s3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_multi(OP_DIVU, 32'h1234, 32'd0);
        wait_idle();
        check("s3_div0", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_multi(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        check("div_ovf", {hi, lo}, 64'h00000000_80000000);

        // Scenario 4: MTHI idle, then MTHI and a second start during a DIV
        do_mt(OP_MTHI, 32'h12345678);
        old_lo = m_lo;
        do_multi(OP_DIV, 32'd100, 32'd7);
        mdu_op = OP_MFLO; #1;
        check("mflo_busy", {32'd0, mdu_out}, {32'd0, old_lo});
        @(negedge clk);
        A = 32'hDEADBEEF; mdu_op = OP_MTHI;
        @(negedge clk);
        A = 32'd9; B = 32'd9; mdu_op = OP_MULT; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = OP_NONE;
        wait_idle();
        check("s4_hilo", {hi, lo}, 64'h00000002_0000000E);

        // Scenario 5: reset in busy cycle 3 cancels the MULT
        @(negedge clk);
        A = 32'd7; B = 32'd9; mdu_op = OP_MULT; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = OP_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("s5_hilo", {hi, lo}, 64'd0);
        check("s5_busy", {63'd0, busy}, 64'd0);
        repeat (8) @(negedge clk);
        check("s5_late", {hi, lo}, 64'd0);
        check("s5_busy_late", {63'd0, busy}, 64'd0);

        // Scenario 6: MADDU carry across LO into HI
        do_mt(OP_MTHI, 32'd0);
        do_mt(OP_MTLO, 32'hFFFFFFFF);
        do_multi(OP_MADDU, 32'd1, 32'd1);
        wait_idle();
`ifdef MDU_MADD_EN
        check("s6", {hi, lo}, 64'h00000001_00000000);
`else
        check("s6", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom();
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            case ($urandom_range(0, 7))
                0: op = OP_MULT;
                1: op = OP_MULTU;
                2: op = OP_DIV;
                3: op = OP_DIVU;
                4: op = OP_MADD;
                5: op = OP_MADDU;
                6: op = OP_MTHI;
                default: op = OP_MTLO;
            endcase
            if (op == OP_MTHI || op == OP_MTLO) do_mt(op, a);
            else begin
                do_multi(op, a, b);
                wait_idle();
            end
            if (i % 5 == 4) check_out();
        end

        wait_idle();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have ports clk (input, 1 bit, the single rising-edge clock) and reset (input, 1 bit, synchronous, active-high), listed first.
REQ-002 A  input  32  forwarded rs operand from the E stage, the same value the ALU receives.
REQ-003 B  input  32  forwarded rt operand from the E stage.
REQ-004 mdu_op  input  4  operation code (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU).
REQ-005 start  input  1  one-cycle qualifier for MULT/MULTU/DIV/DIVU/MADD/MADDU; low when E is stalled or holds a bubble.
REQ-006 busy  output  1  computation in flight; the hazard unit stalls D on (start|busy) for any MDU instruction.
REQ-007 hi  output  32  current HI register.
REQ-008 lo  output  32  current LO register.
REQ-009 mdu_out  output  32  HI for MFHI, LO for MFLO, else 0; combinational; muxed into the E/M result downstream of the ALU.

Function
REQ-010 Latency SHALL be MULT/MULTU/MADD/MADDU = 5 cycles and DIV/DIVU = 10 cycles.
REQ-011 On the edge sampling start=1, the block SHALL latch the computed result into pending registers and load the countdown with the latency.
REQ-012 busy SHALL equal (count != 0); it rises after the start edge and stays high for exactly latency cycles.
REQ-013 HI/LO SHALL take the pending result on the edge at which count goes 1->0; busy falls at the same edge.
REQ-014 MULT SHALL write the signed 64-bit product; MULTU writes the unsigned product; HI holds the upper 32 bits, LO the lower 32 bits.
REQ-015 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU does the same unsigned.
REQ-016 For a divisor of 0, the block SHALL still run 10 busy cycles and leave HI/LO unchanged.
REQ-017 For DIV of 0x80000000 by 0xFFFFFFFF, the block SHALL produce LO = 0x80000000 and HI = 0.
REQ-018 MTHI and MTLO SHALL write A into HI or LO on the next edge, with no busy, and only when count == 0.
REQ-019 The block SHALL ignore start, MTHI and MTLO while busy; no queuing, no restart.
REQ-020 mdu_out SHALL reflect the HI/LO register values even while busy; ordering is enforced by the stall.
REQ-021 The block SHALL ignore start when mdu_op is not a multi-cycle op.

Reset
REQ-022 While reset=1 at an edge, the block SHALL clear HI, LO, the pending registers and the count to 0; busy = 0 on the following cycle.
REQ-023 Reset mid-operation SHALL cancel the operation without writing the pending result.
REQ-024 Reset SHALL take priority over start, MTHI and MTLO in the same cycle.

Configuration
REQ-025 The block SHALL support the macro MDU_MADD_EN.
REQ-026 With MDU_MADD_EN defined, MADD/MADDU SHALL add the signed/unsigned product to {HI,LO} modulo 2^64, using HI/LO as sampled at start.
REQ-027 Without MDU_MADD_EN, MADD/MADDU SHALL be treated as NONE: no busy and no HI/LO change.

Structure
REQ-028 The op codes and the two latency constants SHALL live in the shared header package mdu_pkg, included by the decoder, the hazard unit and this block.
REQ-029 The block SHALL be a single module with no sub-module, since the datapath is one countdown plus pending registers.

Verification
REQ-030 Scenario 1: MULT start, A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 Scenario 2: MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 Scenario 3: DIV, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 Scenario 4: MTHI with A=0x12345678 -> HI updates the next cycle and busy stays 0; the same MTHI issued during a DIV -> HI unaffected; a second start during busy is ignored.
REQ-034 Scenario 5: MULT started, reset asserted in busy cycle 3 -> HI=LO=0 and busy=0 after reset, with no late write.
REQ-035 Scenario 6 (MDU_MADD_EN only): HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro -> no busy and no change.
